// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: IMEM request/ack bus and decoder presentation bus of fetch_ctrl.
// master = fetch_ctrl side, slave = IMEM / decoder side.
interface fetch_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  fetch_en_i;
   logic                  imem_req_o;
   logic [ADDR_WIDTH-1:0] imem_addr_o;
   logic                  imem_ack_i;
   logic [DATA_WIDTH-1:0] imem_rdata_i;
   logic                  instr_valid_o;
   logic [DATA_WIDTH-1:0] instr_rdata_o;
   logic [ADDR_WIDTH-1:0] instr_addr_o;
   logic                  instr_ready_i;
   logic                  valid_pc_i;
   logic                  timeout_o;

   modport master (
      input  fetch_en_i,
      input  imem_ack_i,
      input  imem_rdata_i,
      input  instr_ready_i,
      input  valid_pc_i,
      output imem_req_o,
      output imem_addr_o,
      output instr_valid_o,
      output instr_rdata_o,
      output instr_addr_o,
      output timeout_o
   );

   modport slave (
      output fetch_en_i,
      output imem_ack_i,
      output imem_rdata_i,
      output instr_ready_i,
      output valid_pc_i,
      input  imem_req_o,
      input  imem_addr_o,
      input  instr_valid_o,
      input  instr_rdata_o,
      input  instr_addr_o,
      input  timeout_o
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and IMEM fetch sequencer (IDLE -> REQ -> HOLD) feeding the decoder.
// Ports: clk_i, arst_i (async, active high); bus (fetch_ctrl_if.master):
//   fetch_en_i, imem_req_o/addr_o/ack_i/rdata_i, instr_valid_o/rdata_o/addr_o,
//   instr_ready_i, valid_pc_i, timeout_o (sticky until reset).
// Option macro FETCH_LINE_BUF_EN: serve the upper half of a buffered word
//   without a new IMEM request.
module fetch_ctrl #(
   parameter int unsigned          ADDR_WIDTH  = 32,
   parameter int unsigned          DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
   parameter int unsigned          ACK_TIMEOUT = 16
) (
   input logic          clk_i,
   input logic          arst_i,
   fetch_ctrl_if.master bus
);

   localparam int unsigned CNT_W =
      (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  tmo_q, tmo_d;
   logic                  reuse;

   // pc arithmetic wraps modulo 2^ADDR_WIDTH
   assign pc_inc = pc_q + ADDR_WIDTH'(2);

`ifdef FETCH_LINE_BUF_EN
   // lower half just accepted: the upper half is already in buf_q
   assign reuse = bus.valid_pc_i & ~pc_q[1] & bus.fetch_en_i;
`else
   assign reuse = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.fetch_en_i) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.imem_ack_i) begin
               buf_d   = bus.imem_rdata_i;
               cnt_d   = '0;
               state_d = S_HOLD;
            end else if (cnt_q == CNT_MAX) begin
               tmo_d   = 1'b1;
               pc_d    = BOOT_ADDR;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.instr_ready_i) begin
               pc_d = bus.valid_pc_i ? pc_inc : BOOT_ADDR;
               if (reuse) begin
                  state_d = S_HOLD;
               end else if (bus.fetch_en_i) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= S_IDLE;
         pc_q    <= BOOT_ADDR;
         buf_q   <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.imem_req_o    = (state_q == S_REQ);
   assign bus.imem_addr_o   = pc_q;
   assign bus.instr_valid_o = (state_q == S_HOLD);
   assign bus.instr_rdata_o = buf_q;
   assign bus.instr_addr_o  = pc_q;
   assign bus.timeout_o     = tmo_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, corner sequences and randomized run
// against a transaction-level reference model of fetch_ctrl.
module tb_fetch_ctrl;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 16;
   localparam logic [31:0] W_BOOT = 32'hFFFF_FFFC;
`ifdef FETCH_LINE_BUF_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst = 1'b1;
   logic w_arst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f_if ();
   fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) w_if ();

   fetch_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BOOT_ADDR(32'h0), .ACK_TIMEOUT(TMO)
   ) dut (
      .clk_i(clk), .arst_i(arst), .bus(f_if.master)
   );

   fetch_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BOOT_ADDR(W_BOOT), .ACK_TIMEOUT(2)
   ) u_wrap (
      .clk_i(clk), .arst_i(w_arst), .bus(w_if.master)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mchk(input string tag, input logic e_req, input logic e_vld,
                       input logic [31:0] e_addr, input logic [31:0] e_rd,
                       input logic e_tmo);
      chk({tag, " req"}, 32'(f_if.imem_req_o), 32'(e_req));
      chk({tag, " vld"}, 32'(f_if.instr_valid_o), 32'(e_vld));
      chk({tag, " iaddr"}, f_if.imem_addr_o, e_addr);
      chk({tag, " daddr"}, f_if.instr_addr_o, e_addr);
      chk({tag, " tmo"}, 32'(f_if.timeout_o), 32'(e_tmo));
      if (e_vld) chk({tag, " rdata"}, f_if.instr_rdata_o, e_rd);
   endtask

   task automatic wchk(input string tag, input logic e_req, input logic e_vld,
                       input logic [31:0] e_addr, input logic [31:0] e_rd,
                       input logic e_tmo);
      chk({tag, " req"}, 32'(w_if.imem_req_o), 32'(e_req));
      chk({tag, " vld"}, 32'(w_if.instr_valid_o), 32'(e_vld));
      chk({tag, " iaddr"}, w_if.imem_addr_o, e_addr);
      chk({tag, " daddr"}, w_if.instr_addr_o, e_addr);
      chk({tag, " tmo"}, 32'(w_if.timeout_o), 32'(e_tmo));
      if (e_vld) chk({tag, " rdata"}, w_if.instr_rdata_o, e_rd);
   endtask

   task automatic drv(input logic fen, input logic ack, input logic [31:0] rd,
                      input logic rdy, input logic vpc);
      f_if.fetch_en_i    = fen;
      f_if.imem_ack_i    = ack;
      f_if.imem_rdata_i  = rd;
      f_if.instr_ready_i = rdy;
      f_if.valid_pc_i    = vpc;
   endtask

   task automatic wdrv(input logic fen, input logic ack, input logic [31:0] rd,
                       input logic rdy, input logic vpc);
      w_if.fetch_en_i    = fen;
      w_if.imem_ack_i    = ack;
      w_if.imem_rdata_i  = rd;
      w_if.instr_ready_i = rdy;
      w_if.valid_pc_i    = vpc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model: waiting for IMEM, showing an instr, or neither
   bit          m_wait_ack;
   bit          m_show;
   logic [31:0] m_pc;
   logic [31:0] m_word;
   int          m_waited;
   bit          m_tmo;

   task automatic model_reset();
      m_wait_ack = 0;
      m_show     = 0;
      m_pc       = 32'h0;
      m_word     = 32'h0;
      m_waited   = 0;
      m_tmo      = 0;
   endtask

   task automatic model_clock(input bit fen, input bit ack, input logic [31:0] rd,
                              input bit rdy, input bit vpc);
      bit same_word;
      if (m_wait_ack) begin
         if (ack) begin
            m_word     = rd;
            m_wait_ack = 0;
            m_show     = 1;
            m_waited   = 0;
         end else if (m_waited + 1 >= int'(TMO)) begin
            m_tmo      = 1;
            m_pc       = 32'h0;
            m_wait_ack = 0;
            m_waited   = 0;
         end else begin
            m_waited++;
         end
      end else if (m_show) begin
         if (rdy) begin
            same_word = LB && vpc && fen && (m_pc % 4 == 0);
            m_pc = vpc ? 32'((64'(m_pc) + 2) % 64'h1_0000_0000) : 32'h0;
            if (!same_word) begin
               m_show     = 0;
               m_wait_ack = fen;
            end
         end
      end else if (fen) begin
         m_wait_ack = 1;
      end
   endtask

   typedef struct {
      logic        fen;
      logic        ack;
      logic [31:0] rd;
      logic        rdy;
      logic        vpc;
      logic        e_req;
      logic        e_vld;
      logic [31:0] e_addr;
      logic [31:0] e_rd;
      logic        e_tmo;
   } vec_t;

   function automatic vec_t mk(logic fen, logic ack, logic [31:0] rd,
                               logic rdy, logic vpc, logic e_req, logic e_vld,
                               logic [31:0] e_addr, logic [31:0] e_rd);
      vec_t v;
      v.fen = fen; v.ack = ack; v.rd = rd; v.rdy = rdy; v.vpc = vpc;
      v.e_req = e_req; v.e_vld = e_vld; v.e_addr = e_addr; v.e_rd = e_rd;
      v.e_tmo = 1'b0;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ack_pct;
      bit rst_now;
      bit r_fen, r_ack, r_rdy, r_vpc;
      logic [31:0] r_rd;

      drv(0, 1, 32'hAAAA_5555, 1, 1);
      wdrv(0, 0, 0, 0, 0);

      // reset state, ack during reset ignored
      @(negedge clk);
      mchk("reset", 0, 0, 32'h0, 32'h0, 0);
      chk("reset rdata", f_if.instr_rdata_o, 32'h0);
      tick();
      arst = 1'b0;

`ifndef FETCH_LINE_BUF_EN
      tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0, 32'h0, 0));
      tbl.push_back(mk(1, 1, 32'h1111_0000, 0, 0, 1, 0, 32'h0, 0));
      tbl.push_back(mk(1, 0, 0,            1, 1, 0, 1, 32'h0, 32'h1111_0000));
      tbl.push_back(mk(1, 1, 32'h2222_0001, 0, 0, 1, 0, 32'h2, 0));
      tbl.push_back(mk(1, 0, 0,            1, 1, 0, 1, 32'h2, 32'h2222_0001));
      tbl.push_back(mk(1, 1, 32'h3333_0002, 0, 0, 1, 0, 32'h4, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 1, 32'hDEAD_BEEF, 0, 1, 0, 1, 32'h4, 32'h3333_0002));
      tbl.push_back(mk(1, 0, 0,            1, 1, 0, 1, 32'h4, 32'h3333_0002));
      tbl.push_back(mk(1, 1, 32'h4444_0003, 0, 0, 1, 0, 32'h6, 0));
      tbl.push_back(mk(1, 0, 0,            1, 0, 0, 1, 32'h6, 32'h4444_0003));
      tbl.push_back(mk(1, 1, 32'h5555_0004, 0, 0, 1, 0, 32'h0, 0));
      tbl.push_back(mk(0, 0, 0,            1, 1, 0, 1, 32'h0, 32'h5555_0004));
      tbl.push_back(mk(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 32'h2, 0));
      tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0, 32'h2, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 1, 0, 32'h2, 0));
      tbl.push_back(mk(0, 1, 32'h6666_0005, 0, 0, 1, 0, 32'h2, 0));
      tbl.push_back(mk(0, 0, 0,            1, 1, 0, 1, 32'h2, 32'h6666_0005));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 32'h4, 0));
      foreach (tbl[i]) begin
         drv(tbl[i].fen, tbl[i].ack, tbl[i].rd, tbl[i].rdy, tbl[i].vpc);
         @(negedge clk);
         mchk($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_vld,
              tbl[i].e_addr, tbl[i].e_rd, tbl[i].e_tmo);
         tick();
      end
`else
      // one request serves both halves of word 0
      drv(1, 0, 0, 0, 0);
      @(negedge clk); mchk("lb idle", 0, 0, 32'h0, 0, 0); tick();
      drv(1, 1, 32'h1234_5678, 0, 0);
      @(negedge clk); mchk("lb req0", 1, 0, 32'h0, 0, 0); tick();
      drv(1, 0, 0, 1, 1);
      @(negedge clk); mchk("lb lo", 0, 1, 32'h0, 32'h1234_5678, 0); tick();
      drv(1, 0, 0, 1, 1);
      @(negedge clk); mchk("lb hi", 0, 1, 32'h2, 32'h1234_5678, 0); tick();
      drv(1, 1, 32'h9ABC_DEF0, 0, 0);
      @(negedge clk); mchk("lb req4", 1, 0, 32'h4, 0, 0); tick();
      drv(0, 0, 0, 1, 1);
      @(negedge clk); mchk("lb w4", 0, 1, 32'h4, 32'h9ABC_DEF0, 0); tick();
`endif

      // IMEM never acks: 16 request cycles, then sticky timeout at boot pc
      drv(1, 0, 0, 0, 0);
      tick();
      drv(0, 0, 0, 0, 0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!f_if.imem_req_o) break;
         n++;
         tick();
      end
      chk("tmo req cycles", 32'(n), 32'(TMO));
      mchk("tmo after", 0, 0, 32'h0, 0, 1);
      tick(); tick(); tick();
      @(negedge clk);
      mchk("tmo sticky", 0, 0, 32'h0, 0, 1);
      tick();

      // reset mid-REQ at a nonzero pc, then a late ack
      drv(1, 0, 0, 0, 0); tick();
      drv(1, 1, 32'hC0DE_0000, 0, 0); tick();
      drv(1, 0, 0, 1, 1); tick();
      if (LB) tick();
      drv(1, 0, 0, 0, 0);
      @(negedge clk);
      mchk("pre rst", 1, 0, LB ? 32'h4 : 32'h2, 0, 1);
      #2 arst = 1'b1;
      #1 mchk("in rst", 0, 0, 32'h0, 0, 0);
      tick();
      arst = 1'b0;
      drv(0, 1, 32'hBAD1_BAD1, 0, 0);
      @(negedge clk); mchk("post rst", 0, 0, 32'h0, 0, 0); tick();
      drv(0, 0, 0, 1, 1);
      @(negedge clk); mchk("post rst2", 0, 0, 32'h0, 0, 0); tick();

      // randomized run against the model
      arst = 1'b1;
      model_reset();
      tick();
      arst = 1'b0;
      ack_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) ack_pct = (ack_pct == 50) ? 3 : 50;
         rst_now = ($urandom_range(0, 299) == 0);
         r_fen = ($urandom_range(0, 9) != 0);
         r_ack = ($urandom_range(0, 99) < ack_pct);
         r_rd  = $urandom;
         r_rdy = ($urandom_range(0, 3) != 0);
         r_vpc = ($urandom_range(0, 7) != 0);
         arst = rst_now;
         if (rst_now) model_reset();
         drv(r_fen, r_ack, r_rd, r_rdy, r_vpc);
         @(negedge clk);
         mchk($sformatf("rnd%0d", c), m_wait_ack, m_show, m_pc, m_word, m_tmo);
         if (!rst_now) model_clock(r_fen, r_ack, r_rd, r_rdy, r_vpc);
         tick();
      end
      arst = 1'b0;

      // pc wrap past 0xFFFF_FFFE and minimum ack timeout of 2
      w_arst = 1'b0;
      wdrv(1, 0, 0, 0, 0);
      @(negedge clk); wchk("w idle", 0, 0, W_BOOT, 0, 0); tick();
      wdrv(1, 1, 32'hAB00_0001, 0, 0);
      @(negedge clk); wchk("w req0", 1, 0, W_BOOT, 0, 0); tick();
      wdrv(1, 0, 0, 1, 1);
      @(negedge clk); wchk("w hold0", 0, 1, W_BOOT, 32'hAB00_0001, 0); tick();
`ifndef FETCH_LINE_BUF_EN
      wdrv(1, 1, 32'hAB00_0002, 0, 0);
      @(negedge clk); wchk("w req1", 1, 0, 32'hFFFF_FFFE, 0, 0); tick();
      wdrv(1, 0, 0, 1, 1);
      @(negedge clk); wchk("w hold1", 0, 1, 32'hFFFF_FFFE, 32'hAB00_0002, 0); tick();
`else
      wdrv(1, 0, 0, 1, 1);
      @(negedge clk); wchk("w hold1", 0, 1, 32'hFFFF_FFFE, 32'hAB00_0001, 0); tick();
`endif
      wdrv(0, 0, 0, 0, 0);
      @(negedge clk); wchk("w wrap", 1, 0, 32'h0, 0, 0); tick();
      @(negedge clk); wchk("w wait", 1, 0, 32'h0, 0, 0); tick();
      @(negedge clk); wchk("w tmo", 0, 0, W_BOOT, 0, 1); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
